// File: rtl/pe_pkt_source_if.sv
// rtl/pe_pkt_source_if.sv - handshake bundle between pe_pkt_source and the NoC/PE side
// Purpose: groups the cfg request, load-packet output and result-packet input channels.
// Ports (signals):
//   cfg_valid/cfg_ready/cfg_addr/cfg_ifmap/cfg_filter  load request channel
//   pkt_out_valid/pkt_out_ready/pkt_out_data           load packet toward the PE
//   pkt_in_valid/pkt_in_ready/pkt_in_data              result packets from the PE
// Modports: master = pe_pkt_source side, slave = requester / PE side.
interface pe_pkt_source_if #(
  parameter int WIDTH   = 39,
  parameter int DEPTH_F = 3,
  parameter int DEPTH_I = 5
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [7:0]             cfg_addr;
  logic [DEPTH_I-1:0]     cfg_ifmap;
  logic [8*DEPTH_F-1:0]   cfg_filter;

  logic                   pkt_out_valid;
  logic                   pkt_out_ready;
  logic [WIDTH-1:0]       pkt_out_data;

  logic                   pkt_in_valid;
  logic                   pkt_in_ready;
  logic [WIDTH-1:0]       pkt_in_data;

  modport master (
    input  cfg_valid, cfg_addr, cfg_ifmap, cfg_filter,
    input  pkt_out_ready, pkt_in_valid, pkt_in_data,
    output cfg_ready, pkt_out_valid, pkt_out_data, pkt_in_ready
  );

  modport slave (
    output cfg_valid, cfg_addr, cfg_ifmap, cfg_filter,
    output pkt_out_ready, pkt_in_valid, pkt_in_data,
    input  cfg_ready, pkt_out_valid, pkt_out_data, pkt_in_ready
  );
endinterface

// File: rtl/pe_pkt_source.sv
// rtl/pe_pkt_source.sv - NoC-side load packet injector and result packet collector for a PE node
// Purpose: builds one type-01 load packet per cfg request, sends it, then collects DEPTH_F
//   type-10 result packets, checking type/addr/order, and presents each psum with its tag.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   bus (master modport)   cfg request, load packet out, result packet in
//   psum_valid/data/row/col  one-cycle pulse with the fields of the consumed result
//   busy                   FSM not in IDLE
//   done                   one-cycle pulse at completion or timeout
//   err                    sticky protocol error (cleared by reset only)
//   psum_total             sum of good psums for the current load (only with PE_PKT_PSUM_ACCUM_EN)
// Optional feature macro: PE_PKT_PSUM_ACCUM_EN
module pe_pkt_source #(
  parameter int WIDTH       = 39,
  parameter int DEPTH_F     = 3,
  parameter int DEPTH_I     = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            reset,
  pe_pkt_source_if.master bus,
  output logic            psum_valid,
  output logic [7:0]      psum_data,
  output logic [1:0]      psum_row,
  output logic [1:0]      psum_col,
  output logic            busy,
  output logic            done,
  output logic            err
`ifdef PE_PKT_PSUM_ACCUM_EN
  ,
  output logic [9:0]      psum_total
`endif
);

  localparam int CW = (DEPTH_F > 0) ? $clog2(DEPTH_F + 1) : 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH_F - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pkt_q, pkt_d;
  logic [CW-1:0]    res_cnt_q, res_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             psum_valid_q, psum_valid_d;
  logic [7:0]       psum_data_q, psum_data_d;
  logic [1:0]       psum_row_q, psum_row_d;
  logic [1:0]       psum_col_q, psum_col_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef PE_PKT_PSUM_ACCUM_EN
  logic [9:0]       total_q, total_d;
`endif

  logic [CW-1:0]    cnt_inc;
  logic             res_good;
  logic             timeout_hit;
  logic             unused_pkt_bits;

  // Result payload bits between the tag and the psum carry nothing for this node.
  assign unused_pkt_bits = ^bus.pkt_in_data[23:8];

  assign cnt_inc = res_cnt_q + CW'(1);

  // Column tag is compared modulo 4 against the next expected result index.
  assign res_good = (bus.pkt_in_data[38:37] == 2'b10) &&
                    (bus.pkt_in_data[36:29] == pkt_q[36:29]) &&
                    !bus.pkt_in_data[28] &&
                    (bus.pkt_in_data[25:24] == 2'(cnt_inc));

  assign timeout_hit = TO_EN && (timer_q == TO_LAST);

  assign bus.cfg_ready     = (state_q == IDLE);
  assign bus.pkt_out_valid = (state_q == SEND);
  assign bus.pkt_out_data  = (state_q == SEND) ? pkt_q : '0;
  assign bus.pkt_in_ready  = (state_q == WAIT_RES);
  assign busy              = (state_q != IDLE);
  assign psum_valid        = psum_valid_q;
  assign psum_data         = psum_data_q;
  assign psum_row          = psum_row_q;
  assign psum_col          = psum_col_q;
  assign done              = done_q;
  assign err               = err_q;
`ifdef PE_PKT_PSUM_ACCUM_EN
  assign psum_total        = total_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pkt_q        <= '0;
      res_cnt_q    <= '0;
      timer_q      <= '0;
      psum_valid_q <= 1'b0;
      psum_data_q  <= '0;
      psum_row_q   <= '0;
      psum_col_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef PE_PKT_PSUM_ACCUM_EN
      total_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pkt_q        <= pkt_d;
      res_cnt_q    <= res_cnt_d;
      timer_q      <= timer_d;
      psum_valid_q <= psum_valid_d;
      psum_data_q  <= psum_data_d;
      psum_row_q   <= psum_row_d;
      psum_col_q   <= psum_col_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef PE_PKT_PSUM_ACCUM_EN
      total_q      <= total_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    pkt_d        = pkt_q;
    res_cnt_d    = res_cnt_q;
    timer_d      = timer_q;
    psum_valid_d = 1'b0;
    psum_data_d  = psum_data_q;
    psum_row_d   = psum_row_q;
    psum_col_d   = psum_col_q;
    done_d       = 1'b0;
    err_d        = err_q;
`ifdef PE_PKT_PSUM_ACCUM_EN
    total_d      = total_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          pkt_d   = {2'b01, bus.cfg_addr, bus.cfg_ifmap, bus.cfg_filter};
          state_d = SEND;
`ifdef PE_PKT_PSUM_ACCUM_EN
          total_d = '0;
`endif
        end
      end

      SEND: begin
        if (bus.pkt_out_ready) begin
          state_d   = WAIT_RES;
          res_cnt_d = '0;
          timer_d   = '0;
        end
      end

      WAIT_RES: begin
        if (bus.pkt_in_valid) begin
          // Every result is consumed and echoed, even a bad one; only good
          // results advance the count toward completion.
          timer_d      = '0;
          psum_valid_d = 1'b1;
          psum_data_d  = bus.pkt_in_data[7:0];
          psum_row_d   = bus.pkt_in_data[27:26];
          psum_col_d   = bus.pkt_in_data[25:24];
          if (res_good) begin
            res_cnt_d = cnt_inc;
`ifdef PE_PKT_PSUM_ACCUM_EN
            total_d   = total_q + 10'(bus.pkt_in_data[7:0]);
`endif
            if (res_cnt_q == CNT_LAST) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_pkt_source.sv
// tb/tb_pe_pkt_source.sv - directed table-driven bench for pe_pkt_source
module tb_pe_pkt_source;

  logic       clk;
  logic       reset;
  logic       psum_valid;
  logic [7:0] psum_data;
  logic [1:0] psum_row;
  logic [1:0] psum_col;
  logic       busy;
  logic       done;
  logic       err;
`ifdef PE_PKT_PSUM_ACCUM_EN
  logic [9:0] psum_total;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  pe_pkt_source_if bus ();

  pe_pkt_source #(.TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .psum_valid (psum_valid),
    .psum_data  (psum_data),
    .psum_row   (psum_row),
    .psum_col   (psum_col),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef PE_PKT_PSUM_ACCUM_EN
    ,
    .psum_total (psum_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] typ;
    logic [7:0] addr;
    logic [1:0] row;
    logic [1:0] col;
    logic [7:0] psum;
    logic       exp_err;
    logic       exp_done;
    logic [9:0] exp_total;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".cfg_ready"}, 64'(bus.cfg_ready), 64'd1);
    chk({tag, ".pkt_out_valid"}, 64'(bus.pkt_out_valid), 64'd0);
    chk({tag, ".pkt_out_data"}, 64'(bus.pkt_out_data), 64'd0);
    chk({tag, ".pkt_in_ready"}, 64'(bus.pkt_in_ready), 64'd0);
    chk({tag, ".psum_valid"}, 64'(psum_valid), 64'd0);
    chk({tag, ".psum_fields"}, 64'({psum_data, psum_row, psum_col}), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".err"}, 64'(err), 64'd0);
`ifdef PE_PKT_PSUM_ACCUM_EN
    chk({tag, ".psum_total"}, 64'(psum_total), 64'd0);
`endif
  endtask

  task automatic do_load(input logic [7:0] addr, input logic [4:0] ifmap,
                         input logic [23:0] filter, input logic [38:0] exp_pkt,
                         input int hold);
    int k;
    k = 0;
    while (bus.cfg_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    chk("load.cfg_ready", 64'(bus.cfg_ready), 64'd1);
    bus.cfg_valid  = 1'b1;
    bus.cfg_addr   = addr;
    bus.cfg_ifmap  = ifmap;
    bus.cfg_filter = filter;
    step();
    // While SEND waits, a new request must be ignored.
    bus.cfg_valid  = (hold > 0);
    bus.cfg_addr   = 8'hFF;
    bus.cfg_filter = 24'hFFFFFF;
    for (int c = 0; c < hold; c++) begin
      chk("hold.pkt_out_valid", 64'(bus.pkt_out_valid), 64'd1);
      chk("hold.pkt_out_data", 64'(bus.pkt_out_data), 64'(exp_pkt));
      step();
    end
    bus.cfg_valid     = 1'b0;
    bus.pkt_out_ready = 1'b1;
    chk("load.pkt_out_valid", 64'(bus.pkt_out_valid), 64'd1);
    chk("load.pkt_out_data", 64'(bus.pkt_out_data), 64'(exp_pkt));
    step();
    bus.pkt_out_ready = 1'b0;
    chk("load.pkt_in_ready", 64'(bus.pkt_in_ready), 64'd1);
    chk("load.pkt_out_drop", 64'(bus.pkt_out_valid), 64'd0);
  endtask

  task automatic apply_range(input int lo, input int hi);
    int k;
    for (int i = lo; i <= hi; i++) begin
      bus.pkt_in_data  = {vecs[i].typ, vecs[i].addr, 1'b0, vecs[i].row, vecs[i].col,
                          16'h0000, vecs[i].psum};
      bus.pkt_in_valid = 1'b1;
      k = 0;
      while (bus.pkt_in_ready !== 1'b1 && k < 50) begin
        step();
        k++;
      end
      chk("res.pkt_in_ready", 64'(bus.pkt_in_ready), 64'd1);
      step();
      bus.pkt_in_valid = 1'b0;
      chk($sformatf("v%0d.psum_valid", i), 64'(psum_valid), 64'd1);
      chk($sformatf("v%0d.psum_data", i), 64'(psum_data), 64'(vecs[i].psum));
      chk($sformatf("v%0d.psum_row", i), 64'(psum_row), 64'(vecs[i].row));
      chk($sformatf("v%0d.psum_col", i), 64'(psum_col), 64'(vecs[i].col));
      chk($sformatf("v%0d.err", i), 64'(err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d.done", i), 64'(done), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d.cfg_ready", i), 64'(bus.cfg_ready), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'(!vecs[i].exp_done));
`ifdef PE_PKT_PSUM_ACCUM_EN
      chk($sformatf("v%0d.psum_total", i), 64'(psum_total), 64'(vecs[i].exp_total));
`endif
    end
    step();
    chk("idle.psum_valid", 64'(psum_valid), 64'd0);
    chk("idle.done", 64'(done), 64'd0);
  endtask

  initial begin
    // typ, addr, row, col, psum, err, done, total
    vecs[0]  = '{2'b10, 8'h04, 2'd1, 2'd1, 8'd7,    1'b0, 1'b0, 10'd7};
    vecs[1]  = '{2'b10, 8'h04, 2'd1, 2'd2, 8'd9,    1'b0, 1'b0, 10'd16};
    vecs[2]  = '{2'b10, 8'h04, 2'd1, 2'd3, 8'd3,    1'b0, 1'b1, 10'd19};
    vecs[3]  = '{2'b10, 8'h33, 2'd2, 2'd2, 8'd5,    1'b1, 1'b0, 10'd0};
    vecs[4]  = '{2'b10, 8'h33, 2'd2, 2'd1, 8'd1,    1'b1, 1'b0, 10'd1};
    vecs[5]  = '{2'b01, 8'h33, 2'd2, 2'd2, 8'h40,   1'b1, 1'b0, 10'd1};
    vecs[6]  = '{2'b10, 8'h34, 2'd2, 2'd2, 8'h41,   1'b1, 1'b0, 10'd1};
    vecs[7]  = '{2'b10, 8'h33, 2'd2, 2'd2, 8'd2,    1'b1, 1'b0, 10'd3};
    vecs[8]  = '{2'b10, 8'h33, 2'd2, 2'd3, 8'd4,    1'b1, 1'b1, 10'd7};
    vecs[9]  = '{2'b10, 8'h22, 2'd3, 2'd1, 8'h55,   1'b0, 1'b0, 10'd85};
    vecs[10] = '{2'b10, 8'h22, 2'd0, 2'd1, 8'd10,   1'b0, 1'b0, 10'd10};
    vecs[11] = '{2'b10, 8'h22, 2'd0, 2'd2, 8'd20,   1'b0, 1'b0, 10'd30};
    vecs[12] = '{2'b10, 8'h22, 2'd0, 2'd3, 8'd30,   1'b0, 1'b1, 10'd60};

    reset             = 1'b1;
    bus.cfg_valid     = 1'b0;
    bus.cfg_addr      = '0;
    bus.cfg_ifmap     = '0;
    bus.cfg_filter    = '0;
    bus.pkt_out_ready = 1'b0;
    bus.pkt_in_valid  = 1'b0;
    bus.pkt_in_data   = '0;
    repeat (3) step();
    check_reset("rst0");
    reset = 1'b0;
    step();

    // Basic load and in-order results.
    do_load(8'h04, 5'b11101, 24'h0E0508, 39'h20_9D0E_0508, 0);
    apply_range(0, 2);

    // Back-pressure for 10 cycles, then out-of-order / wrong type / wrong addr results.
    do_load(8'h33, 5'b00010, 24'hA1B2C3, 39'h26_62A1_B2C3, 10);
    apply_range(3, 8);

    reset = 1'b1;
    step();
    check_reset("rst1");
    reset = 1'b0;
    step();

    // Timeout: no results, done exactly 16 cycles after the SEND handshake.
    do_load(8'h11, 5'b00000, 24'h000000, 39'h22_2000_0000, 0);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c < 16) begin
        if (done !== 1'b0) begin
          chk($sformatf("to.early_done_c%0d", c), 64'(done), 64'd0);
        end
      end else begin
        chk("to.done", 64'(done), 64'd1);
        chk("to.err", 64'(err), 64'd1);
        chk("to.cfg_ready", 64'(bus.cfg_ready), 64'd1);
        chk("to.busy", 64'(busy), 64'd0);
      end
    end
    step();
    chk("to.done_pulse", 64'(done), 64'd0);
    chk("to.err_sticky", 64'(err), 64'd1);
    chk("to.cfg_ready_next", 64'(bus.cfg_ready), 64'd1);

    reset = 1'b1;
    step();
    check_reset("rst2");
    reset = 1'b0;
    step();

    // Reset after one of three results, then a full load.
    do_load(8'h22, 5'b10000, 24'h010203, 39'h24_5001_0203, 0);
    apply_range(9, 9);
    reset = 1'b1;
    step();
    check_reset("rst_mid");
    reset = 1'b0;
    step();
    do_load(8'h22, 5'b10000, 24'h010203, 39'h24_5001_0203, 0);
    apply_range(10, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
